code_entry_checker: RTL
=======================

// Module: code_entry_checker
// PURPOSE
//  Reader side of the digit-entry path: consumes 4-bit BCD digits produced by the
//  button-driven digit counters, one per accept strobe, and checks the completed
//  code against a fixed secret. Drives the unlock output for a bounded time.
//  Enforces a timed lockout after repeated failed attempts.
//  Sits between the digit counters/debounced buttons and the lock actuator/status LEDs.
// PARAMETERS
//  CODE_LEN       4          digits per code (1..8)
//  SECRET         16'h1234   secret code, BCD, most-significant digit entered first; width 4*CODE_LEN
//  MAX_FAIL       3          consecutive failures that trigger lockout (>=1)
//  OPEN_CYCLES    50_000_000 clk cycles unlocked stays high
//  LOCK_CYCLES    250_000_000 clk cycles lockout lasts
// PORTS
//  clk          in   1            system clock, rising edge
//  rst_n        in   1            asynchronous active-low reset
//  digit        in   4            current digit value from digit counter
//  accept       in   1            1-cycle strobe: capture digit (debounced, synchronous upstream)
//  clear        in   1            1-cycle strobe: discard partial entry / relock early
//  unlocked     out  1            high while in OPEN
//  locked_out   out  1            high while in LOCKOUT
//  err          out  1            1-cycle pulse on each failed check
//  entered      out  4            digits captured in current attempt (0..CODE_LEN)
//  fail_cnt     out  4            consecutive failures so far (0..MAX_FAIL-1)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=ENTRY; unlocked=0, locked_out=0, err=0, entered=0,
//   fail_cnt=0, digit buffer=0, timer=0. Release is synchronous to clk.
//  States: ENTRY, CHECK, OPEN, LOCKOUT. All outputs registered.
//  ENTRY: accept=1 -> shift digit into buffer (buf <= {buf[4*CODE_LEN-5:0],digit}),
//   entered++. Digit >9 is captured and counted, sets bad flag (forces mismatch).
//   When accept arrives with entered==CODE_LEN-1 -> CHECK next cycle, entered reads CODE_LEN.
//   clear=1 -> entered=0, bad=0, stay ENTRY. clear and accept same cycle: clear wins, digit dropped.
//  CHECK (exactly 1 cycle, accept/clear ignored): match = (buf==SECRET)&&!bad.
//   match -> OPEN, fail_cnt=0, timer=OPEN_CYCLES-1.
//   mismatch & fail_cnt==MAX_FAIL-1 -> LOCKOUT, err pulse, fail_cnt=0, timer=LOCK_CYCLES-1.
//   mismatch otherwise -> ENTRY, err pulse, fail_cnt++.
//   In all cases entered=0, bad=0 on leaving CHECK.
//  Latency: last accept at cycle N -> err or unlocked/locked_out asserted at cycle N+2.
//  OPEN: unlocked=1 for exactly OPEN_CYCLES cycles, then ENTRY. clear=1 -> ENTRY next
//   cycle (early relock). accept ignored (digits not buffered).
//  LOCKOUT: locked_out=1 for exactly LOCK_CYCLES cycles, then ENTRY; accept and clear ignored.
//  Timer: down-counter, width $clog2(max(OPEN_CYCLES,LOCK_CYCLES)+1); no wrap (reloaded on entry).
//  Reset mid-operation: immediate return to reset values; partial entry and fail count lost.
//  err is high for exactly one cycle per failed check; never high with unlocked.
// TESTING
//  (bench params: CODE_LEN=4, SECRET=16'h1234, MAX_FAIL=3, OPEN_CYCLES=8, LOCK_CYCLES=16)
//  1 accept 1,2,3,4 -> unlocked high 2 cycles after 4th accept for exactly 8 cycles; fail_cnt=0.
//  2 accept 1,2,3,5 twice -> err pulse each, fail_cnt 1 then 2; third wrong code -> locked_out
//    high 16 cycles, accepts ignored throughout, then correct code unlocks.
//  3 accept 1,2 then clear, then 1,2,3,4 -> unlocked; clear+accept same cycle -> entered unchanged.
//  4 digit 4'hA among four accepts with buffer otherwise 1234-like -> err, no unlock.
//  5 during OPEN clear at cycle 3 -> unlocked low next cycle; during ENTRY with entered=3
//    assert rst_n=0 -> all outputs 0 asynchronously, entered=0.
//  6 one wrong code, then correct code -> fail_cnt returns to 0; three more wrongs needed to lock.

Source files
------------

// File: rtl/code_entry_checker.sv
// code_entry_checker: collects BCD digits per accept strobe, checks them against SECRET,
// then holds a timed unlock or, after MAX_FAIL consecutive misses, a timed lockout.
module code_entry_checker #(
    parameter int                    CODE_LEN    = 4,
    parameter logic [4*CODE_LEN-1:0] SECRET      = 16'h1234,
    parameter int                    MAX_FAIL    = 3,
    parameter int                    OPEN_CYCLES = 50_000_000,
    parameter int                    LOCK_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit,
    input  logic       accept,
    input  logic       clear,
    output logic       unlocked,
    output logic       locked_out,
    output logic       err,
    output logic [3:0] entered,
    output logic [3:0] fail_cnt
);
    localparam int W    = 4 * CODE_LEN;
    localparam int MAXC = OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCKOUT} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  code_buf;
    logic          bad;
    logic [TW-1:0] timer;
    logic          match, last_try, last_digit;

    assign match      = (code_buf == SECRET) && !bad;
    assign last_try   = fail_cnt == 4'(MAX_FAIL - 1);
    assign last_digit = entered == 4'(CODE_LEN - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ENTRY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ENTRY:   state_nx = !clear && accept && last_digit ? CHECK : ENTRY;
            CHECK:   state_nx = match ? OPEN : last_try ? LOCKOUT : ENTRY;
            OPEN:    state_nx = clear || timer == '0 ? ENTRY : OPEN;
            LOCKOUT: state_nx = timer == '0 ? ENTRY : LOCKOUT;
            default: state_nx = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_buf <= '0;
            bad      <= 1'b0;
            entered  <= '0;
            fail_cnt <= '0;
            timer    <= '0;
            err      <= 1'b0;
        end else begin
            err <= state == CHECK && !match;
            case (state)
                ENTRY: begin
                    if (clear) begin
                        entered <= '0;
                        bad     <= 1'b0;
                    end else if (accept) begin
                        code_buf <= W'({code_buf, digit});
                        entered  <= entered + 4'd1;
                        bad      <= bad || digit > 4'd9;
                    end
                end
                CHECK: begin
                    entered <= '0;
                    bad     <= 1'b0;
                    if (match) begin
                        fail_cnt <= '0;
                        timer    <= TW'(OPEN_CYCLES - 1);
                    end else if (last_try) begin
                        fail_cnt <= '0;
                        timer    <= TW'(LOCK_CYCLES - 1);
                    end else begin
                        fail_cnt <= fail_cnt + 4'd1;
                    end
                end
                default: if (timer != '0) timer <= timer - TW'(1);
            endcase
        end
    end

    always_comb begin
        unlocked   = state == OPEN;
        locked_out = state == LOCKOUT;
    end
endmodule
